// File: rtl/sram_read_client.sv
// sram_read_client: one requester port of sram_bus. It walks a programmed address window,
// keeps at most one read outstanding, and buffers the returned words in a small prefetch
// FIFO that is drained downstream over a valid/ready handshake.
// Optional feature macro: SRAM_READ_CLIENT_LOOP_EN. When defined, fetching wraps to the
// window base after the last word and keeps going until a zero-length start or a reset.
module sram_read_client #(
   parameter int unsigned ADDRESS_BUS_WIDTH = 16,
   parameter int unsigned DATA_BUS_WIDTH    = 16,
   parameter int unsigned LENGTH_WIDTH      = 16,
   parameter int unsigned FIFO_DEPTH        = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [ADDRESS_BUS_WIDTH-1:0] base_address,
   input  logic [LENGTH_WIDTH-1:0]      length,
   output logic                         read_request,
   output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
   input  logic                         read_finished_strobe,
   input  logic [DATA_BUS_WIDTH-1:0]    read_data,
   output logic [DATA_BUS_WIDTH-1:0]    data_out,
   output logic                         data_valid,
   input  logic                         data_ready,
   output logic                         busy,
   output logic                         done
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StFetch, StWait} state_e;

   state_e                         state_q;
   logic                           pending_q;
   logic                           drop_q;     // in-flight word belongs to an abandoned window
   logic                           done_q;
   logic [ADDRESS_BUS_WIDTH-1:0]   base_q;
   logic [ADDRESS_BUS_WIDTH-1:0]   addr_q;
   logic [LENGTH_WIDTH-1:0]        len_q;
   logic [LENGTH_WIDTH-1:0]        index_q;

   logic [DATA_BUS_WIDTH-1:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]                wr_ptr_q;
   logic [PtrW-1:0]                rd_ptr_q;
   logic [CntW-1:0]                count_q;

   logic                           push;
   logic                           pop;
   logic                           last;

   // FIFO push/pop qualification; a start flushes, so it suppresses both.
   always_comb begin
      push = (state_q == StWait) && pending_q && read_finished_strobe && !drop_q && !start;
      pop  = (count_q != '0) && data_ready && !start;
      last = (index_q == (len_q - LENGTH_WIDTH'(1)));
   end

   // Prefetch FIFO storage and pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (start) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= read_data;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CntW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CntW'(1);
         end
      end
   end

   // Request sequencer: window bookkeeping, single outstanding read, done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         pending_q <= 1'b0;
         drop_q    <= 1'b0;
         done_q    <= 1'b0;
         base_q    <= '0;
         len_q     <= '0;
         index_q   <= '0;
         addr_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            base_q  <= base_address;
            len_q   <= length;
            index_q <= '0;
            if (pending_q && !read_finished_strobe) begin
               // Bus still owes us a word; wait for it and throw it away.
               drop_q  <= 1'b1;
               state_q <= StWait;
            end else begin
               pending_q <= 1'b0;
               drop_q    <= 1'b0;
               state_q   <= (length != '0) ? StFetch : StIdle;
            end
         end else begin
            unique case (state_q)
               StIdle: begin
               end
               StFetch: begin
                  if (count_q < FullCount) begin
                     pending_q <= 1'b1;
                     addr_q    <= base_q + ADDRESS_BUS_WIDTH'(index_q);
                     state_q   <= StWait;
                  end
               end
               StWait: begin
                  if (pending_q && read_finished_strobe) begin
                     pending_q <= 1'b0;
                     if (drop_q) begin
                        drop_q  <= 1'b0;
                        state_q <= (len_q != '0) ? StFetch : StIdle;
                     end else if (last) begin
                        done_q <= 1'b1;
`ifdef SRAM_READ_CLIENT_LOOP_EN
                        index_q <= '0;
                        state_q <= StFetch;
`else
                        state_q <= StIdle;
`endif
                     end else begin
                        index_q <= index_q + LENGTH_WIDTH'(1);
                        state_q <= StFetch;
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   // Request is masked in the strobe cycle so the arbiter never sees a stale request.
   always_comb begin
      read_request = pending_q & ~read_finished_strobe;
      read_address = addr_q;
      data_out     = mem_q[rd_ptr_q];
      data_valid   = (count_q != '0);
      busy         = (state_q != StIdle) | pending_q;
      done         = done_q;
   end

endmodule

// File: tb/tb_sram_read_client.sv
// Testbench for sram_read_client: a behavioural sram_bus arbiter and a consumer model,
// checked against window arithmetic (n-th request / n-th word derived from base and length).
module tb_sram_read_client;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] base_address;
   logic [15:0] length;
   logic        read_request;
   logic [15:0] read_address;
   logic        read_finished_strobe;
   logic [15:0] read_data;
   logic [15:0] data_out;
   logic        data_valid;
   logic        data_ready;
   logic        busy;
   logic        done;

   sram_read_client #(
      .ADDRESS_BUS_WIDTH(16),
      .DATA_BUS_WIDTH   (16),
      .LENGTH_WIDTH     (16),
      .FIFO_DEPTH       (4)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .base_address        (base_address),
      .length              (length),
      .read_request        (read_request),
      .read_address        (read_address),
      .read_finished_strobe(read_finished_strobe),
      .read_data           (read_data),
      .data_out            (data_out),
      .data_valid          (data_valid),
      .data_ready          (data_ready),
      .busy                (busy),
      .done                (done)
   );

   always #5 clk = ~clk;

   int vec  = 0;
   int errs = 0;

   // Reference window model.
   logic [15:0] win_base = 16'h0;
   int          win_len  = 1;
   int          iss_n    = 0;
   int          pop_n    = 0;
   int          done_n   = 0;
   int          lat_fixed = 0;

   // Arbiter state.
   bit          arb_busy = 1'b0;
   int          arb_cnt  = 0;
   logic [15:0] arb_addr = 16'h0;

   function automatic logic [15:0] word_of(input logic [15:0] a);
      return a + 16'h00A0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Arbiter: serves one request at a time after a latency, drives foreign data otherwise.
   always @(negedge clk) begin
      bit          ok;
      logic [15:0] exp_a;
      if (rst) begin
         arb_busy             = 1'b0;
         read_finished_strobe = 1'b0;
         read_data            = 16'($urandom);
      end else if (read_finished_strobe) begin
         read_finished_strobe = 1'b0;
         arb_busy             = 1'b0;
         read_data            = 16'($urandom);
      end else if (arb_busy) begin
         check("addr_stable", read_address, arb_addr);
         check("req_held", read_request, 1);
         arb_cnt--;
         if (arb_cnt == 0) begin
            read_finished_strobe = 1'b1;
            read_data            = word_of(arb_addr);
            #1;
            check("req_masked_in_strobe", read_request, 0);
         end else begin
            read_data = 16'($urandom);
         end
      end else begin
         read_data = 16'($urandom);
         if (read_request === 1'b1) begin
            ok = (win_len != 0);
`ifndef SRAM_READ_CLIENT_LOOP_EN
            ok = ok && (iss_n < win_len);
`endif
            check("req_allowed", 32'(ok), 1);
            if (ok) begin
               exp_a = win_base + 16'(iss_n % win_len);
               check("req_addr", read_address, exp_a);
            end
            iss_n++;
            arb_busy = 1'b1;
            arb_addr = read_address;
            arb_cnt  = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
         end
      end
   end

   // Consumer: every accepted word must be the next word of the current window.
   always @(negedge clk) begin
      bit          ok;
      logic [15:0] exp_a;
      if (!rst && !start) begin
         if (done === 1'b1) done_n++;
         if (data_valid === 1'b1 && data_ready) begin
            ok = (win_len != 0);
`ifndef SRAM_READ_CLIENT_LOOP_EN
            ok = ok && (pop_n < win_len);
`endif
            check("pop_allowed", 32'(ok), 1);
            if (ok) begin
               exp_a = win_base + 16'(pop_n % win_len);
               check("data_out", data_out, word_of(exp_a));
            end
            pop_n++;
         end
      end
   end

   task automatic do_start(input logic [15:0] b, input logic [15:0] l);
      base_address = b;
      length       = l;
      start        = 1'b1;
      tick();
      start    = 1'b0;
      win_base = b;
      win_len  = int'(l);
      iss_n    = 0;
      pop_n    = 0;
      done_n   = 0;
   endtask

   task automatic run_until_idle(input int budget, input bit rnd);
      int n = 0;
      while ((busy || data_valid) && n < budget) begin
         if (rnd) data_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      data_ready = 1'b1;
      check("idle_within_budget", 32'(n < budget), 1);
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      base_address = 16'h0;
      length       = 16'h0;
      data_ready   = 1'b1;
      repeat (3) tick();
      check("rst_req", read_request, 0);
      check("rst_addr", read_address, 0);
      check("rst_valid", data_valid, 0);
      check("rst_dout", data_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst = 1'b0;
      tick();

`ifdef SRAM_READ_CLIENT_LOOP_EN
      // Looping window.
      lat_fixed = 3;
      do_start(16'h0040, 16'd2);
      repeat (60) tick();
      check("loop_busy", busy, 1);
      check("loop_dones", 32'(done_n >= 3), 1);
      check("loop_pops", 32'(pop_n >= 6), 1);
      do_start(16'h0000, 16'd0);
      run_until_idle(40, 1'b0);
      check("loop_stop_busy", busy, 0);
`else
      // Basic window.
      lat_fixed = 3;
      do_start(16'h0010, 16'd3);
      run_until_idle(200, 1'b0);
      check("t1_pops", pop_n, 3);
      check("t1_reqs", iss_n, 3);
      check("t1_dones", done_n, 1);

      // Backpressure: the FIFO depth bounds outstanding fetches.
      lat_fixed  = 0;
      data_ready = 1'b0;
      do_start(16'h0300, 16'd8);
      repeat (60) tick();
      check("t2_reqs_gated", iss_n, 4);
      check("t2_req_low", read_request, 0);
      check("t2_valid", data_valid, 1);
      check("t2_no_pops", pop_n, 0);
      data_ready = 1'b1;
      run_until_idle(300, 1'b0);
      check("t2_pops", pop_n, 8);
      check("t2_reqs", iss_n, 8);
      check("t2_dones", done_n, 1);

      // Address wrap.
      do_start(16'hFFFE, 16'd4);
      run_until_idle(200, 1'b1);
      check("t3_pops", pop_n, 4);
      check("t3_dones", done_n, 1);

      // Restart while a read is outstanding: in-flight word must be dropped.
      lat_fixed = 3;
      do_start(16'h0100, 16'd4);
      begin
         int n = 0;
         while (read_request !== 1'b1 && n < 30) begin
            tick();
            n++;
         end
         check("t4_req_seen", 32'(n < 30), 1);
      end
      do_start(16'h0200, 16'd2);
      run_until_idle(200, 1'b0);
      check("t4_pops", pop_n, 2);
      check("t4_reqs", iss_n, 2);
      check("t4_dones", done_n, 1);

      // Random windows with random latency and random consumer readiness.
      lat_fixed = 0;
      for (int k = 0; k < 6; k++) begin
         logic [15:0] b;
         logic [15:0] l;
         b = 16'($urandom);
         l = 16'($urandom_range(1, 9));
         do_start(b, l);
         run_until_idle(600, 1'b1);
         check("rnd_pops", pop_n, int'(l));
         check("rnd_reqs", iss_n, int'(l));
         check("rnd_dones", done_n, 1);
      end

      // Reset in the middle of a window.
      data_ready = 1'b0;
      do_start(16'h0700, 16'd8);
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      data_ready = 1'b1;
      win_len = 0;
      iss_n   = 0;
      pop_n   = 0;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", data_valid, 0);
      check("mid_rst_req", read_request, 0);
      check("mid_rst_addr", read_address, 0);

      // Zero-length start: nothing happens.
      do_start(16'h0500, 16'd0);
      repeat (10) tick();
      check("t5_busy", busy, 0);
      check("t5_reqs", iss_n, 0);
      check("t5_valid", data_valid, 0);
      check("t5_dones", done_n, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
